kernel_loader: RTL

//  Transmit end of the per-tap kernel configuration interface (cfg_ker/cfg_val) of the

---
 rtl/kernel_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/kernel_loader.sv
// kernel_loader: stages a TAPS-word kernel frame, then strobes it into the tap chain.
// Optional macro KER_REVERSE_EN: tap j receives stage[TAPS-1-j].
module kernel_loader #(
  parameter int KER_WIDTH = 16,
  parameter int TAPS      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KER_WIDTH-1:0] up_ker,
  input  logic                 up_val,
  input  logic                 up_last,
  output logic                 up_rdy,
  output logic [KER_WIDTH-1:0] cfg_ker,
  output logic [TAPS-1:0]      cfg_val,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int CW = $clog2(TAPS);
  localparam logic [CW-1:0] LAST = CW'(TAPS-1);

  typedef enum logic [1:0] {
    FILL,
    DROP,
    LOAD
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [KER_WIDTH-1:0] stage_q [TAPS];
  logic [KER_WIDTH-1:0] stage_d [TAPS];
  logic up_rdy_q, up_rdy_d;
  logic [KER_WIDTH-1:0] cfg_ker_q, cfg_ker_d;
  logic [TAPS-1:0] cfg_val_q, cfg_val_d;
  logic cfg_done_q, cfg_done_d;
  logic cfg_err_q, cfg_err_d;
  logic busy_q, busy_d;

  logic acc;
  logic [CW-1:0] sel;
  logic [KER_WIDTH-1:0] first;

  // Tap 0 is driven in the cycle after the last word, so in reversed
  // order it comes straight from the word being accepted.
`ifdef KER_REVERSE_EN
  assign sel   = LAST - idx_q;
  assign first = up_ker;
`else
  assign sel   = idx_q;
  assign first = stage_q[0];
`endif

  assign acc = up_val & up_rdy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stage_d    = stage_q;
    cfg_ker_d  = cfg_ker_q;
    cfg_val_d  = '0;
    cfg_done_d = 1'b0;
    cfg_err_d  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (up_last) begin
              stage_d[cnt_q] = up_ker;
              state_d   = LOAD;
              cfg_val_d = TAPS'(1);
              cfg_ker_d = first;
              idx_d     = CW'(1);
            end else begin
              cfg_err_d = 1'b1;
              state_d   = DROP;
            end
          end else if (up_last) begin
            cnt_d     = '0;
            cfg_err_d = 1'b1;
          end else begin
            stage_d[cnt_q] = up_ker;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (acc && up_last) state_d = FILL;
      end
      LOAD: begin
        if (cfg_val_q[TAPS-1]) begin
          state_d    = FILL;
          cfg_done_d = 1'b1;
        end else begin
          cfg_val_d = cfg_val_q << 1;
          cfg_ker_d = stage_q[sel];
          idx_d     = idx_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    up_rdy_d = (state_d != LOAD);
    busy_d   = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      idx_q      <= '0;
      up_rdy_q   <= 1'b0;
      cfg_ker_q  <= '0;
      cfg_val_q  <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      up_rdy_q   <= up_rdy_d;
      cfg_ker_q  <= cfg_ker_d;
      cfg_val_q  <= cfg_val_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign up_rdy   = up_rdy_q;
  assign cfg_ker  = cfg_ker_q;
  assign cfg_val  = cfg_val_q;
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign busy     = busy_q;

endmodule
